hilo_mdu: RTL and testbench

HILO_MDU -- requirements
Module: hilo_mdu

---
 rtl/hilo_mdu_if.sv | 33 +++
 rtl/hilo_mdu.sv | 202 ++++++++++++++++++++
 tb/tb_hilo_mdu.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if -- request/result bundle for the HI/LO multiply-divide unit.
//
// Signals (master = requester, slave = hilo_mdu):
//   flush  : synchronous abort of the current or presented operation
//   start  : operation valid strobe, sampled on the rising clock edge
//   op     : operation code (MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI, MTLO)
//   a, b   : operands
//   busy   : high while a divide is in progress
//   done   : one-cycle pulse in the cycle after HI and/or LO is written
//   hi, lo : architectural HI and LO register values
interface hilo_mdu_if #(
  parameter int W = 32
);
  logic         flush;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output flush, start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  flush, start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_mdu.sv
// hilo_mdu -- HI/LO multiply / divide unit.
//
// Multiplies, multiply-accumulates and HI/LO moves complete in the cycle they
// are accepted. Divides run a restoring shift-subtract loop, one quotient bit
// per cycle, on operand magnitudes, followed by one sign-fix cycle that
// writes LO = quotient and HI = remainder.
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
//   bus : hilo_mdu_if slave modport (flush, start, op, a, b -> busy, done,
//         hi, lo)
module hilo_mdu #(
  parameter int W = 32
) (
  input  logic       clk,
  input  logic       rst,
  hilo_mdu_if.slave  bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;
  logic          busy_q;
  logic          done_q;

  // Divider datapath: quo_q starts as the dividend magnitude and is shifted
  // left one bit per iteration while quotient bits enter at the bottom.
  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  dvs_q;
  logic          neg_quo_q;   // quotient must be negated in FIX
  logic          neg_rem_q;   // remainder must be negated in FIX
  logic          dz_q;        // divisor was zero

  // Combinational helpers
  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] prod_u;
  logic [2*W-1:0] acc;
  logic           accept;
  logic           is_signed;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     rem_sh;
  logic [W:0]     trial;
  logic [W-1:0]   rem_d;
  logic [W-1:0]   quo_d;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  assign accept = (state_q == S_IDLE) && bus.start && !bus.flush;
  assign acc    = {hi_q, lo_q};

  always_comb begin
    // Full-width products: operands are extended to 2W bits so the low 2W
    // bits of the product are exact for both signed and unsigned forms.
    prod_s = {{W{bus.a[W-1]}}, bus.a} * {{W{bus.b[W-1]}}, bus.b};
    prod_u = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};

    is_signed = (bus.op == OP_DIV);
    a_neg     = is_signed && bus.a[W-1];
    b_neg     = is_signed && bus.b[W-1];
    // Negating the most-negative value yields the same bit pattern, which is
    // the correct unsigned magnitude 2^(W-1).
    a_mag     = a_neg ? -bus.a : bus.a;
    b_mag     = b_neg ? -bus.b : bus.b;
  end

  always_comb begin
    // One restoring iteration: bring down the next dividend bit and keep the
    // subtraction only if it did not borrow.
    rem_sh = {rem_q, quo_q[W-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    rem_d  = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
    quo_d  = {quo_q[W-2:0], ~trial[W]};

    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MULT: begin
                {hi_q, lo_q} <= prod_s;
                done_q       <= 1'b1;
              end
              OP_MULTU: begin
                {hi_q, lo_q} <= prod_u;
                done_q       <= 1'b1;
              end
              OP_MADD: begin
                {hi_q, lo_q} <= acc + prod_s;
                done_q       <= 1'b1;
              end
              OP_MSUB: begin
                {hi_q, lo_q} <= acc - prod_s;
                done_q       <= 1'b1;
              end
              OP_MTHI: begin
                hi_q   <= bus.a;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= bus.a;
                done_q <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                quo_q     <= a_mag;
                rem_q     <= '0;
                dvs_q     <= b_mag;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                dz_q      <= (bus.b == '0);
                cnt_q     <= CW'(W - 1);
                busy_q    <= 1'b1;
                state_q   <= S_DIV;
              end
              default: ;
            endcase
          end
        end

        S_DIV: begin
          if (bus.flush) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == '0) begin
              state_q <= S_FIX;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end

        S_FIX: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!bus.flush) begin
            // A zero divisor leaves the dividend in the remainder already;
            // only the quotient needs forcing to all ones.
            lo_q   <= dz_q ? '1 : quo_fix;
            hi_q   <= rem_fix;
            done_q <= 1'b1;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu -- self-checking bench for hilo_mdu (W = 32).
// A transaction-level reference model predicts hi/lo/busy/done; a compare
// process checks them every falling edge, and directed vectors add literal
// expectations.
module tb_hilo_mdu;

  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  logic clk;
  logic rst;

  hilo_mdu_if #(.W(W)) ifc ();

  hilo_mdu #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] p_hi, p_lo;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
      end else begin
        bit nd;
        nd = 1'b0;
        if (m_busy) begin
          if (ifc.flush) begin
            m_busy = 1'b0;
          end else if (m_cnt == 1) begin
            m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; nd = 1'b1;
          end else begin
            m_cnt--;
          end
        end else if (ifc.start && !ifc.flush) begin
          int              sa, sb;
          longint          ps;
          longint unsigned ua, ub;
          logic [63:0]     hl;
          sa = ifc.a; sb = ifc.b;
          ua = 64'(ifc.a); ub = 64'(ifc.b);
          ps = longint'(sa) * longint'(sb);
          hl = {m_hi, m_lo};
          nd = 1'b1;
          case (ifc.op)
            OP_MULT:  {m_hi, m_lo} = ps;
            OP_MULTU: {m_hi, m_lo} = ua * ub;
            OP_MADD:  {m_hi, m_lo} = hl + ps;
            OP_MSUB:  {m_hi, m_lo} = hl - ps;
            OP_MTHI:  m_hi = ifc.a;
            OP_MTLO:  m_lo = ifc.a;
            default: begin
              nd = 1'b0;
              if (ifc.b == 32'h0) begin
                p_lo = '1; p_hi = ifc.a;
              end else if (ifc.op == OP_DIV) begin
                if (ifc.a == 32'h8000_0000 && ifc.b == 32'hFFFF_FFFF) begin
                  p_lo = 32'h8000_0000; p_hi = 32'h0;
                end else begin
                  p_lo = sa / sb; p_hi = sa % sb;
                end
              end else begin
                p_lo = ifc.a / ifc.b; p_hi = ifc.a % ifc.b;
              end
              m_busy = 1'b1;
              m_cnt  = W + 1;
            end
          endcase
        end
        m_done = nd;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_hi",   ifc.hi,          m_hi);
      check("cyc_lo",   ifc.lo,          m_lo);
      check("cyc_busy", 32'(ifc.busy),   32'(m_busy));
      check("cyc_done", 32'(ifc.done),   32'(m_done));
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge; returns at the falling edge of the cycle after
  // the accepting rising edge.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ifc.op = op; ifc.a = a; ifc.b = b; ifc.start = 1'b1;
    $display("op=%0d a=%h b=%h flush=%0b t=%0t", op, a, b, ifc.flush, $time);
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_div(output int n);
    n = 0;
    while (ifc.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    rst = 1'b1;
    ifc.flush = 1'b0; ifc.start = 1'b0; ifc.op = 3'b0; ifc.a = '0; ifc.b = '0;
    repeat (2) @(negedge clk);
    check("rst_hi",   ifc.hi, 32'h0);
    check("rst_lo",   ifc.lo, 32'h0);
    check("rst_busy", 32'(ifc.busy), 32'h0);
    rst = 1'b0;

    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi",   ifc.hi, 32'hFFFF_FFFF);
    check("mult_lo",   ifc.lo, 32'hFFFF_FFFA);
    check("mult_done", 32'(ifc.done), 32'h1);
    check("mult_busy", 32'(ifc.busy), 32'h0);

    do_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
    do_op(OP_MTHI, 32'd5, 32'h0);
    check("mthi_lo_kept", ifc.lo, 32'hFFFF_FFFF);
    do_op(OP_MADD, 32'd2, 32'd3);
    check("madd_hi", ifc.hi, 32'd6);
    check("madd_lo", ifc.lo, 32'd5);
    do_op(OP_MSUB, 32'd2, 32'd3);
    check("msub_hi", ifc.hi, 32'd5);
    check("msub_lo", ifc.lo, 32'hFFFF_FFFF);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", ifc.hi, 32'hFFFF_FFFE);
    check("multu_lo", ifc.lo, 32'h0000_0001);

    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_div(n);
    check("div_busy_cycles", 32'(n), 32'd33);
    check("div_lo",   ifc.lo, 32'hFFFF_FFFD);
    check("div_hi",   ifc.hi, 32'hFFFF_FFFF);
    check("div_done", 32'(ifc.done), 32'h1);

    do_op(OP_DIVU, 32'd100, 32'd0);
    wait_div(n);
    check("divz_lo", ifc.lo, 32'hFFFF_FFFF);
    check("divz_hi", ifc.hi, 32'd100);

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_div(n);
    check("divovf_lo", ifc.lo, 32'h8000_0000);
    check("divovf_hi", ifc.hi, 32'h0);

    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_div(n);
    check("div_7_m2_lo", ifc.lo, 32'hFFFF_FFFD);
    check("div_7_m2_hi", ifc.hi, 32'd1);

    do_op(OP_DIVU, 32'd100, 32'd7);
    wait_div(n);
    check("divu_lo", ifc.lo, 32'd14);
    check("divu_hi", ifc.hi, 32'd2);

    // Flush mid-divide
    do_op(OP_DIV, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    ifc.flush = 1'b1;
    $display("flush t=%0t", $time);
    @(negedge clk);
    ifc.flush = 1'b0;
    check("flush_busy", 32'(ifc.busy), 32'h0);
    check("flush_hi",   ifc.hi, 32'd2);
    check("flush_lo",   ifc.lo, 32'd14);
    check("flush_done", 32'(ifc.done), 32'h0);
    do_op(OP_MULTU, 32'd6, 32'd7);
    check("post_flush_lo", ifc.lo, 32'd42);
    check("post_flush_hi", ifc.hi, 32'd0);

    // Flush together with start in idle: suppressed
    ifc.flush = 1'b1;
    do_op(OP_MTHI, 32'd99, 32'h0);
    ifc.flush = 1'b0;
    check("flstart_hi",   ifc.hi, 32'd0);
    check("flstart_done", 32'(ifc.done), 32'h0);

    // Start while busy ignored, then async reset mid-divide
    do_op(OP_DIV, 32'd50, 32'd5);
    repeat (3) @(negedge clk);
    do_op(OP_MTLO, 32'h0000_DEAD, 32'h0);
    check("ign_lo",   ifc.lo, 32'd42);
    check("ign_busy", 32'(ifc.busy), 32'h1);
    #2 rst = 1'b1;
    $display("rst pulse t=%0t", $time);
    #1;
    check("arst_hi",   ifc.hi, 32'h0);
    check("arst_lo",   ifc.lo, 32'h0);
    check("arst_busy", 32'(ifc.busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_op(OP_MULT, 32'd4, 32'd5);
    check("post_rst_lo",   ifc.lo, 32'd20);
    check("post_rst_done", 32'(ifc.done), 32'h1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
